reg_mem_initiator: RTL

Bus initiator for the single-cycle register-memory protocol (sel/wr/addr/wdata out, rdata/ready in). It takes one command at a time from an upstream valid/ready command channel, drives the transaction onto the memory port, and returns read data on a response channel with backpressure. It sits between a CPU-side or test-sequencer command source and a register memory responder.

---
 rtl/reg_mem_initiator.sv | 129 ++++++++++++
 1 files changed

// File: rtl/reg_mem_initiator.sv
// Single-command initiator for the register-memory bus: command in, sel/wr/addr/wdata out, read data back.
// Optional ISSUE timeout abort is enabled by defining REG_MEM_INIT_TIMEOUT_EN.
`timescale 1ns/1ps
module reg_mem_initiator #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  mem_sel,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_t;

    state_t state;
    state_t state_nxt;
    logic   timeout_hit;

    // Only registered state and rsp_ready feed the command handshake.
    assign cmd_ready = (state == IDLE) && (!rsp_valid || rsp_ready);
    assign busy      = (state != IDLE);

`ifdef REG_MEM_INIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             rsp_err_q;

    // The TIMEOUT-th not-ready cycle aborts at its closing edge; mem_ready high takes priority.
    assign timeout_hit = (state == ISSUE) && !mem_ready && (to_cnt == CNT_W'(TIMEOUT - 1));
    assign rsp_err     = rsp_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state != ISSUE) begin
            to_cnt <= '0;
        end else if (!mem_ready) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    // ISSUE waits indefinitely in this build.
    assign timeout_hit = 1'b0 && (TIMEOUT > 0);
    assign rsp_err     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (mem_ready)        state_nxt = mem_wr ? IDLE : RWAIT;
                else if (timeout_hit) state_nxt = IDLE;
            end
            RWAIT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_sel   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
`ifdef REG_MEM_INIT_TIMEOUT_EN
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        mem_sel   <= 1'b1;
                        mem_wr    <= cmd_wr;
                        mem_addr  <= cmd_addr;
                        mem_wdata <= cmd_wdata;
                    end
                end
                ISSUE: begin
                    // Reads keep sel high through RWAIT so the responder can re-raise ready.
                    if (mem_ready) begin
                        if (mem_wr) mem_sel <= 1'b0;
                    end else if (timeout_hit) begin
                        mem_sel   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
`ifdef REG_MEM_INIT_TIMEOUT_EN
                        rsp_err_q <= 1'b1;
`endif
                    end
                end
                RWAIT: begin
                    mem_sel   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_data  <= mem_rdata;
`ifdef REG_MEM_INIT_TIMEOUT_EN
                    rsp_err_q <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
